// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, stall, flush and forwarding control for a 5-stage pipeline
//
// Ports:
//   clk, rst_n                     clock (rising edge), asynchronous active-low reset
//   rsD, rtD / rsE, rtE            source registers of the instructions in Decode / Execute
//   writeregE/M/W, regwriteE/M/W   destination register and write enable in E/M/W
//   memtoregE, memtoregM           load instruction in E/M
//   branchD                        Decode branch compares rsD/rtD
//   pcsrcD                         Decode resolved a taken branch/jump this cycle
//   imem_ready                     instruction word for the current pcF is valid
//   stallF, stallD                 hold pc_IF / IF_ID (1 = hold)
//   flushD, flushE                 clear IF_ID / ID_EX
//   forwardAD, forwardBD           Decode comparator operand from the M-stage result
//   forwardAE, forwardBE           ALU operand select: 00 regfile, 01 W result, 10 M result
//   stall_count                    saturating count of cycles with stallF=1

module pipe_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             pcsrcD,
    input  logic             imem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] DISCARD = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       lwstall;
    logic       branchstall;
    logic       dstall;
    logic       fwait;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] w, input logic [REG_W-1:0] r);
        return (r != '0) && (w == r);
    endfunction

    function automatic logic [1:0] alu_fwd(input logic [REG_W-1:0] r);
        if (regwriteM && reg_hit(writeregM, r)) begin
            return 2'b10;
        end else if (regwriteW && reg_hit(writeregW, r)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign lwstall     = memtoregE && (reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD));
    assign branchstall = branchD &&
                         ((regwriteE && (reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD))) ||
                          (memtoregM && (reg_hit(writeregM, rsD) || reg_hit(writeregM, rtD))));
    assign dstall      = lwstall || branchstall;
    assign fwait       = !imem_ready;

    always_comb begin
        state_nxt = state;
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b1;
        flushE    = 1'b1;
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        forwardAD = 1'b0;
        forwardBD = 1'b0;
        if (rst_n) begin
            forwardAE = alu_fwd(rsE);
            forwardBE = alu_fwd(rtE);
            forwardAD = regwriteM && reg_hit(writeregM, rsD);
            forwardBD = regwriteM && reg_hit(writeregM, rtD);
            case (state)
                RUN: begin
                    stallD = dstall;
                    flushE = dstall;
                    stallF = dstall || fwait;
                    // A data stall freezes D, so it also suppresses any redirect.
                    flushD = !dstall && (pcsrcD || fwait);
                    // Redirect while a fetch is outstanding: let the PC take the
                    // target now, and remember that the old word is still coming.
                    if (pcsrcD && fwait && !dstall) begin
                        stallF    = 1'b0;
                        state_nxt = DISCARD;
                    end
                end
                default: begin
                    // Waiting for the abandoned fetch; its word is flushed, never latched.
                    stallF = 1'b1;
                    stallD = 1'b0;
                    flushD = 1'b1;
                    flushE = 1'b0;
                    if (imem_ready) begin
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            if (stallF && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard testbench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, pcsrcD, imem_ready;

    logic        stallF, stallD, flushD, flushE, forwardAD, forwardBD;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] stall_count;

    logic        s_stallF, s_stallD, s_flushD, s_flushE, s_forwardAD, s_forwardBD;
    logic [1:0]  s_forwardAE, s_forwardBE;
    logic [3:0]  s_stall_count;

    // Expected {stallF, stallD, flushD, flushE, forwardAE, forwardBE, forwardAD, forwardBD}
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    logic [9:0] got_v;
    int         n_checks;
    int         n_pass;

    pipe_hazard_ctrl #(.CNT_W(32), .REG_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .imem_ready(imem_ready),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAD(forwardAD), .forwardBD(forwardBD),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stall_count(stall_count)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .REG_W(5)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .pcsrcD(pcsrcD), .imem_ready(imem_ready),
        .stallF(s_stallF), .stallD(s_stallD), .flushD(s_flushD), .flushE(s_flushE),
        .forwardAD(s_forwardAD), .forwardBD(s_forwardBD),
        .forwardAE(s_forwardAE), .forwardBE(s_forwardBE),
        .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observe();
        return {stallF, stallD, flushD, flushE, forwardAE, forwardBE, forwardAD, forwardBD};
    endfunction

    task automatic idle();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0;
        branchD = 0; pcsrcD = 0; imem_ready = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        regwriteM = 1; writeregM = 5; rsE = 5; imem_ready = 0;
        exp_q.push_back(10'b0011_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL reset_outputs: got %b want %b", got_v, exp_v); else n_pass++;
        n_checks++;
        if (stall_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", stall_count); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        idle();
        rst_n = 1;
    endtask

    task automatic test_forwarding();
        logic [9:0] stim_exp [4];
        stim_exp[0] = 10'b0000_10_10_1_0;
        stim_exp[1] = 10'b0000_01_01_0_0;
        stim_exp[2] = 10'b0000_00_01_0_0;
        stim_exp[3] = 10'b0000_00_01_1_1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            regwriteW = 1; writeregW = 5;
            case (i)
                0: begin regwriteM = 1; writeregM = 5; rsE = 5; rtE = 5; rsD = 5; end
                1: begin regwriteM = 0; writeregM = 5; rsE = 5; rtE = 5; rsD = 5; end
                2: begin regwriteM = 1; writeregM = 0; rsE = 0; rtE = 5; rsD = 0; end
                default: begin regwriteM = 1; writeregM = 9; rsD = 9; rtD = 9; rsE = 0; rtE = 5; end
            endcase
            exp_q.push_back(stim_exp[i]);
            #1;
            exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
            if (got_v !== exp_v) $display("FAIL forward_%0d: got %b want %b", i, got_v, exp_v); else n_pass++;
        end
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        @(negedge clk);
        idle();
        c0 = stall_count;
        memtoregE = 1; regwriteE = 1; writeregE = 7; rsD = 7;
        exp_q.push_back(10'b1101_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL load_use: got %b want %b", got_v, exp_v); else n_pass++;
        @(negedge clk);
        idle();
        memtoregE = 1; regwriteE = 1; writeregE = 0; rsD = 0; rtD = 0;
        exp_q.push_back(10'b0000_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL load_use_r0: got %b want %b", got_v, exp_v); else n_pass++;
        n_checks++;
        if (stall_count !== c0 + 32'd1) $display("FAIL load_use_count: got %0d want %0d", stall_count, c0 + 32'd1); else n_pass++;
    endtask

    task automatic test_branch();
        logic [9:0] stim_exp [4];
        stim_exp[0] = 10'b1101_00_00_00;
        stim_exp[1] = 10'b0000_00_00_00;
        stim_exp[2] = 10'b1101_00_00_00;
        stim_exp[3] = 10'b0010_00_00_00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle();
            case (i)
                0: begin branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3; pcsrcD = 1; end
                1: ;
                2: begin branchD = 1; memtoregM = 1; writeregM = 4; rsD = 4; end
                default: begin branchD = 1; regwriteE = 1; writeregE = 0; rsD = 0; pcsrcD = 1; end
            endcase
            exp_q.push_back(stim_exp[i]);
            #1;
            exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
            if (got_v !== exp_v) $display("FAIL branch_%0d: got %b want %b", i, got_v, exp_v); else n_pass++;
        end
    endtask

    task automatic test_fetch_wait();
        logic [31:0] c0;
        @(negedge clk);
        idle();
        c0 = stall_count;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            idle();
            imem_ready = 0;
            exp_q.push_back(10'b1010_00_00_00);
            #1;
            exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
            if (got_v !== exp_v) $display("FAIL fetch_wait_%0d: got %b want %b", i, got_v, exp_v); else n_pass++;
        end
        @(negedge clk);
        idle();
        #1;
        n_checks++;
        if (stall_count !== c0 + 32'd3) $display("FAIL fetch_wait_count: got %0d want %0d", stall_count, c0 + 32'd3); else n_pass++;
    endtask

    task automatic test_redirect();
        logic [9:0]  stim_exp [5];
        logic [31:0] c0;
        stim_exp[0] = 10'b0010_00_00_00;
        stim_exp[1] = 10'b1010_00_00_00;
        stim_exp[2] = 10'b1010_00_00_00;
        stim_exp[3] = 10'b1010_00_00_00;
        stim_exp[4] = 10'b0000_00_00_00;
        @(negedge clk);
        idle();
        c0 = stall_count;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            idle();
            case (i)
                0: begin imem_ready = 0; pcsrcD = 1; end
                1: imem_ready = 0;
                2: begin imem_ready = 0; pcsrcD = 1; end
                3: imem_ready = 1;
                default: ;
            endcase
            exp_q.push_back(stim_exp[i]);
            #1;
            exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
            if (got_v !== exp_v) $display("FAIL redirect_%0d: got %b want %b", i, got_v, exp_v); else n_pass++;
        end
        n_checks++;
        if (stall_count !== c0 + 32'd3) $display("FAIL redirect_count: got %0d want %0d", stall_count, c0 + 32'd3); else n_pass++;
    endtask

    task automatic test_saturation_async_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        @(negedge clk);
        rst_n = 1;
        imem_ready = 0;
        for (int i = 0; i < 20; i++) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s_stall_count !== 4'hF) $display("FAIL saturate_4bit: got %h want f", s_stall_count); else n_pass++;
        n_checks++;
        if (stall_count !== 32'd20) $display("FAIL count_32bit: got %0d want 20", stall_count); else n_pass++;
        idle();
        imem_ready = 0; pcsrcD = 1;
        exp_q.push_back(10'b0010_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL pre_discard: got %b want %b", got_v, exp_v); else n_pass++;
        @(negedge clk);
        idle();
        imem_ready = 0;
        exp_q.push_back(10'b1010_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL in_discard: got %b want %b", got_v, exp_v); else n_pass++;
        #2;
        rst_n = 0;
        exp_q.push_back(10'b0011_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL async_reset_out: got %b want %b", got_v, exp_v); else n_pass++;
        n_checks++;
        if (stall_count !== 32'd0 || s_stall_count !== 4'd0)
            $display("FAIL async_reset_count: got %0d/%0d want 0/0", stall_count, s_stall_count);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        idle();
        exp_q.push_back(10'b0000_00_00_00);
        #1;
        exp_v = exp_q.pop_front(); got_v = observe(); n_checks++;
        if (got_v !== exp_v) $display("FAIL run_after_reset: got %b want %b", got_v, exp_v); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_fetch_wait();
        test_redirect();
        test_saturation_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
